// File: rtl/mem_link_pkg.sv
// Shared definitions for the 2-bit serial memory link: header codes,
// the RX start pattern and the receiver/reply state encodings.
package mem_link_pkg;

  typedef enum logic [1:0] {
    TX_HEADER_READ_16  = 2'd0,
    TX_HEADER_WRITE_8  = 2'd1,
    TX_HEADER_WRITE_16 = 2'd2,
    TX_HEADER_ILLEGAL  = 2'd3
  } tx_header_e;

  localparam logic [1:0] RX_START_PATTERN = 2'b01;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HEADER,
    RX_PAYLOAD
  } rx_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_START,
    R_DATA
  } reply_state_e;

  function automatic logic is_write(input tx_header_e hdr);
    return (hdr == TX_HEADER_WRITE_8) || (hdr == TX_HEADER_WRITE_16);
  endfunction

endpackage

// File: rtl/mem_reply_tx.sv
// Reply serializer: optional idle delay, one start cycle, then the latched
// reply word shifted out LSB-first, NSHIFT bits per cycle.
module mem_reply_tx
  import mem_link_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int REPLY_DELAY    = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [NSHIFT*PAYLOAD_CYCLES-1:0]   word,
  output logic [NSHIFT-1:0]                  rx_pins,
  output logic                               idle
);

  localparam int WORD_W = NSHIFT * PAYLOAD_CYCLES;

  reply_state_e        state_reg;
  logic [3:0]          cnt_reg;
  logic [WORD_W-1:0]   word_reg;
  logic [NSHIFT-1:0]   rx_pins_reg;

  // rx_pins_reg is updated on the same edge as the state so the pins
  // always reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= R_IDLE;
      cnt_reg     <= '0;
      word_reg    <= '0;
      rx_pins_reg <= '0;
    end else begin
      case (state_reg)
        R_IDLE: begin
          if (start) begin
            word_reg <= word;
            if (REPLY_DELAY == 0) begin
              state_reg   <= R_START;
              rx_pins_reg <= RX_START_PATTERN;
            end else begin
              state_reg <= R_WAIT;
              cnt_reg   <= 4'(REPLY_DELAY - 1);
            end
          end
        end
        R_WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg   <= R_START;
            rx_pins_reg <= RX_START_PATTERN;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        R_START: begin
          state_reg   <= R_DATA;
          rx_pins_reg <= word_reg[NSHIFT-1:0];
          word_reg    <= word_reg >> NSHIFT;
          cnt_reg     <= 4'(PAYLOAD_CYCLES - 1);
        end
        R_DATA: begin
          if (cnt_reg == 4'd0) begin
            state_reg   <= R_IDLE;
            rx_pins_reg <= '0;
          end else begin
            rx_pins_reg <= word_reg[NSHIFT-1:0];
            word_reg    <= word_reg >> NSHIFT;
            cnt_reg     <= cnt_reg - 4'd1;
          end
        end
        default: begin
          state_reg   <= R_IDLE;
          rx_pins_reg <= '0;
        end
      endcase
    end
  end

  assign rx_pins = rx_pins_reg;
  assign idle    = (state_reg == R_IDLE);

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the serial link: receives TX commands,
// executes them on a small byte RAM and hands read replies to mem_reply_tx.
module mem_responder
  import mem_link_pkg::*;
#(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int MEM_ADDR_BITS  = 5,
  parameter int REPLY_DELAY    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSHIFT-1:0]        tx_pins,
  output logic [NSHIFT-1:0]        rx_pins,
  output logic                     busy,
  output logic                     overrun,
  output logic                     bad_cmd,
  input  logic [MEM_ADDR_BITS-1:0] peek_addr,
  output logic [7:0]               peek_data
);

  localparam int RAM_SIZE = 1 << MEM_ADDR_BITS;
  localparam int CNT_W    = $clog2(PAYLOAD_CYCLES);
  localparam int WORD_W   = NSHIFT * PAYLOAD_CYCLES;

  rx_state_e                  rx_state_reg;
  tx_header_e                 hdr_reg;
  logic [CNT_W-1:0]           cnt_reg;
  logic [WORD_W-NSHIFT-1:0]   shift_reg;
  logic [MEM_ADDR_BITS-1:0]   last_addr_reg;
  logic                       overrun_reg;
  logic                       bad_cmd_reg;
  logic [7:0]                 mem [RAM_SIZE];

  logic                       exec;
  logic [WORD_W-1:0]          payload;
  logic [MEM_ADDR_BITS-1:0]   rd_addr;
  logic [MEM_ADDR_BITS-1:0]   rd_addr_p1;
  logic [MEM_ADDR_BITS-1:0]   last_addr_p1;
  logic                       reply_idle;
  logic                       reply_start;
  logic [WORD_W-1:0]          reply_word;

  // The final payload group is still on the pins when the command executes,
  // so the full word is assembled combinationally from the shifter.
  assign exec         = (rx_state_reg == RX_PAYLOAD) && (cnt_reg == CNT_W'(PAYLOAD_CYCLES - 1));
  assign payload      = {tx_pins, shift_reg};
  assign rd_addr      = payload[MEM_ADDR_BITS-1:0];
  assign rd_addr_p1   = rd_addr + MEM_ADDR_BITS'(1);
  assign last_addr_p1 = last_addr_reg + MEM_ADDR_BITS'(1);
  assign reply_word   = {mem[rd_addr_p1], mem[rd_addr]};
  assign reply_start  = exec && (hdr_reg == TX_HEADER_READ_16) && reply_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_reg  <= RX_IDLE;
      hdr_reg       <= TX_HEADER_READ_16;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      last_addr_reg <= '0;
      overrun_reg   <= 1'b0;
      bad_cmd_reg   <= 1'b0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (tx_pins[0]) rx_state_reg <= RX_HEADER;
        end
        RX_HEADER: begin
          hdr_reg      <= tx_header_e'(tx_pins);
          cnt_reg      <= '0;
          rx_state_reg <= RX_PAYLOAD;
        end
        RX_PAYLOAD: begin
          shift_reg <= {tx_pins, shift_reg[WORD_W-NSHIFT-1:NSHIFT]};
          cnt_reg   <= cnt_reg + CNT_W'(1);
          if (exec) begin
            rx_state_reg <= RX_IDLE;
            case (hdr_reg)
              TX_HEADER_READ_16: begin
                last_addr_reg <= rd_addr;
                if (!reply_idle) overrun_reg <= 1'b1;
              end
              TX_HEADER_ILLEGAL: bad_cmd_reg <= 1'b1;
              default: ;
            endcase
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAM_SIZE; i++) mem[i] <= '0;
    end else if (exec && is_write(hdr_reg)) begin
      mem[last_addr_reg] <= payload[7:0];
      if (hdr_reg == TX_HEADER_WRITE_16) mem[last_addr_p1] <= payload[15:8];
    end
  end

  mem_reply_tx #(
    .NSHIFT         (NSHIFT),
    .PAYLOAD_CYCLES (PAYLOAD_CYCLES),
    .REPLY_DELAY    (REPLY_DELAY)
  ) u_reply_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (reply_start),
    .word    (reply_word),
    .rx_pins (rx_pins),
    .idle    (reply_idle)
  );

  assign busy      = (rx_state_reg != RX_IDLE) || !reply_idle;
  assign overrun   = overrun_reg;
  assign bad_cmd   = bad_cmd_reg;
  assign peek_data = mem[peek_addr];

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-level model of
// the RAM, last read address, reply timing and sticky flags.
module tb_mem_responder;

  localparam int RD  = 4;
  localparam int MAB = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     tx_pins = 2'b00;
  logic [1:0]     rx_pins;
  logic           busy;
  logic           overrun;
  logic           bad_cmd;
  logic [MAB-1:0] peek_addr = '0;
  logic [7:0]     peek_data;

  mem_responder #(
    .NSHIFT         (2),
    .PAYLOAD_CYCLES (8),
    .MEM_ADDR_BITS  (MAB),
    .REPLY_DELAY    (RD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_pins   (tx_pins),
    .rx_pins   (rx_pins),
    .busy      (busy),
    .overrun   (overrun),
    .bad_cmd   (bad_cmd),
    .peek_addr (peek_addr),
    .peek_data (peek_data)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state.
  logic [7:0]  mem_m [32];
  int          last_m = 0;
  bit          ovr_m = 1'b0;
  bit          bad_m = 1'b0;
  int          reply_last_m = -100;
  int          exp_t[$];
  logic [15:0] exp_w[$];
  int          got_t[$];
  logic [15:0] got_w[$];
  int          stray_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RX monitor: collects complete frames with the cycle of their start beat.
  initial begin
    bit          in_frame = 1'b0;
    int          beat = 0;
    int          t_start = 0;
    logic [15:0] w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        beat = 0;
      end else if (!in_frame) begin
        if (rx_pins == 2'b01) begin
          in_frame = 1'b1;
          t_start = cyc;
          beat = 0;
          w = '0;
        end else if (rx_pins != 2'b00) begin
          stray_cnt++;
        end
      end else begin
        w[2*beat +: 2] = rx_pins;
        beat++;
        if (beat == 8) begin
          got_t.push_back(t_start);
          got_w.push_back(w);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_pins = {1'($urandom), 1'b0};
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h00;
    last_m = 0;
    ovr_m = 1'b0;
    bad_m = 1'b0;
    reply_last_m = -100;
    exp_t.delete();
    exp_w.delete();
  endtask

  task automatic send(input logic [1:0] hdr, input logic [15:0] pl);
    int t0;
    int a;
    @(negedge clk);
    t0 = cyc;
    tx_pins = {1'($urandom), 1'b1};
    @(negedge clk);
    check("busy_in_header", {31'b0, busy}, 32'd1);
    tx_pins = hdr;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_pins = pl[2*i +: 2];
    end
    case (hdr)
      2'd0: begin
        a = int'(pl[4:0]);
        last_m = a;
        if (t0 + 9 > reply_last_m) begin
          exp_t.push_back(t0 + 10 + RD);
          exp_w.push_back({mem_m[(a + 1) % 32], mem_m[a]});
          reply_last_m = t0 + 18 + RD;
        end else begin
          ovr_m = 1'b1;
        end
      end
      2'd1: mem_m[last_m] = pl[7:0];
      2'd2: begin
        mem_m[last_m] = pl[7:0];
        mem_m[(last_m + 1) % 32] = pl[15:8];
      end
      default: bad_m = 1'b1;
    endcase
    $display("tx t0=%0d hdr=%0d payload=0x%04h last_addr=%0d", t0, hdr, pl, last_m);
  endtask

  task automatic peek_lit(input int addr, input logic [7:0] val);
    peek_addr = MAB'(addr);
    #1;
    check($sformatf("peek_lit[%0d]", addr), {24'b0, peek_data}, {24'b0, val});
  endtask

  task automatic peek_sweep();
    for (int a = 0; a < 32; a++) begin
      peek_addr = MAB'(a);
      #1;
      check($sformatf("peek[%0d]", a), {24'b0, peek_data}, {24'b0, mem_m[a]});
    end
  endtask

  task automatic drain();
    int k = 0;
    idle(1);
    while (busy && k < 300) begin
      idle(1);
      k++;
    end
    check("drain_busy", {31'b0, busy}, 32'd0);
    idle(2);
    check("rx_frames", got_t.size(), exp_t.size());
    while (exp_t.size() > 0 && got_t.size() > 0) begin
      check("rx_start_cycle", got_t.pop_front(), exp_t.pop_front());
      check("rx_word", {16'b0, got_w.pop_front()}, {16'b0, exp_w.pop_front()});
    end
    exp_t.delete();
    exp_w.delete();
    got_t.delete();
    got_w.delete();
    check("overrun", {31'b0, overrun}, {31'b0, ovr_m});
    check("bad_cmd", {31'b0, bad_cmd}, {31'b0, bad_m});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    idle(3);
    check("reset_rx_pins", {30'b0, rx_pins}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_overrun", {31'b0, overrun}, 32'd0);
    check("reset_bad_cmd", {31'b0, bad_cmd}, 32'd0);
    peek_sweep();
    rst_n = 1'b1;
    idle(2);

    // Write through a READ_16-selected address, then read it back.
    send(2'd0, 16'h0004);
    send(2'd2, 16'hBEEF);
    idle(1);
    check("busy_after_write_reply_pending", {31'b0, busy}, 32'd1);
    peek_lit(4, 8'hEF);
    peek_lit(5, 8'hBE);
    drain();
    send(2'd0, 16'h0004);
    drain();

    // Address wrap: 0x1F and 0x00 form one reply word.
    send(2'd0, 16'h001F);
    send(2'd1, 16'h0012);
    send(2'd0, 16'h0000);
    send(2'd1, 16'h0034);
    drain();
    send(2'd0, 16'hFFFF);
    drain();

    // WRITE_8 touches only the low byte.
    send(2'd0, 16'h0003);
    send(2'd1, 16'h00AA);
    idle(1);
    check("busy_after_write8", {31'b0, busy}, 32'd1);
    peek_lit(3, 8'hAA);
    peek_lit(4, 8'hEF);
    drain();

    // Back-to-back reads: second reply dropped, address still taken.
    send(2'd0, 16'h0004);
    send(2'd0, 16'h001F);
    drain();
    check("overrun_literal", {31'b0, overrun}, 32'd1);
    send(2'd1, 16'h0055);
    idle(1);
    peek_lit(31, 8'h55);
    drain();

    // Illegal header: payload consumed, nothing written, no reply.
    send(2'd3, 16'h5555);
    drain();
    check("bad_cmd_literal", {31'b0, bad_cmd}, 32'd1);
    peek_sweep();

    // Randomized traffic with occasional gaps.
    for (int n = 0; n < 60; n++) begin
      int r;
      logic [1:0] h;
      r = $urandom_range(0, 9);
      h = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      send(h, 16'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    drain();
    peek_sweep();

    // Reset while the reply is in its data beats.
    send(2'd0, 16'h0004);
    void'(exp_t.pop_back());
    void'(exp_w.pop_back());
    idle(RD + 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_reply_rx", {30'b0, rx_pins}, 32'd0);
    check("rst_mid_reply_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_reply_overrun", {31'b0, overrun}, 32'd0);
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(1);
    peek_sweep();
    send(2'd0, 16'h0002);
    send(2'd2, 16'hCAFE);
    drain();
    send(2'd0, 16'h0002);
    drain();
    peek_lit(2, 8'hFE);
    peek_lit(3, 8'hCA);

    check("stray_rx_beats", stray_cnt, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side end of the CPU's 2-bit serial memory link. It deserializes TX messages (read16/write8/write16 commands) driven by the CPU's scheduler onto `tx_pins`, executes them against an internal byte-addressed RAM, and serializes RX reply messages for reads back onto `rx_pins`. It sits outside the CPU core: it is the bench/FPGA memory model and the reference responder for the link protocol.

## Interface
- `NSHIFT`, 2: link width in bits per cycle; only 2 is supported.
- `PAYLOAD_CYCLES`, 8: payload cycles per message (16 bits / NSHIFT).
- `MEM_ADDR_BITS`, 5: RAM holds 2^MEM_ADDR_BITS bytes.
- `REPLY_DELAY`, 1: idle cycles between end of read command and RX start; range 0..15.

- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_pins`  in  NSHIFT  serial command input from the CPU.
- `rx_pins`  out  NSHIFT  serial reply output to the CPU.
- `busy`  out  1  high while a command is being received or a reply is pending or being sent.
- `overrun`  out  1  sticky: a read completed while a previous reply was still pending/sending.
- `bad_cmd`  out  1  sticky: header code 3 received.
- `peek_addr`  in  MEM_ADDR_BITS  bench backdoor address.
- `peek_data`  out  8  combinational `mem[peek_addr]`.

## Operation
- TX frame: start cycle (`tx_pins[0]`=1, `tx_pins[1]` ignored) while receiver idle; one header cycle (`tx_pins` = command); PAYLOAD_CYCLES payload cycles, least significant 2-bit group first.
- Commands: 0 = READ_16 (payload = address), 1 = WRITE_8, 2 = WRITE_16 (payload = data, address = last READ_16 address), 3 = illegal.
- Receiver FSM: IDLE -> HEADER -> PAYLOAD (counter 0..PAYLOAD_CYCLES-1) -> IDLE. The command executes on the last payload cycle's edge.
- READ_16 at A: latch `last_addr`=A and reply word `{mem[A+1], mem[A]}`. Use A modulo RAM size; A+1 wraps to 0.
- WRITE_16 with data D: `mem[last_addr]`=D[7:0], `mem[last_addr+1]`=D[15:8] (wrapping). WRITE_8: `mem[last_addr]`=D[7:0] only. Writes produce no reply and do not change `last_addr`.
- Illegal header: the payload is consumed and discarded, and `bad_cmd` is set.
- Reply FSM: R_IDLE -> R_WAIT (REPLY_DELAY cycles, skipped if 0) -> R_START (`rx_pins`=2'b01) -> R_DATA (8 cycles, reply word LSB-first) -> R_IDLE. `rx_pins`=0 in R_IDLE and R_WAIT.
- Reply word is latched at command execution, so later writes do not alter an in-flight reply.
- The receiver runs independently of the reply FSM (full duplex). A new command may start the cycle after the previous payload ends.
- READ_16 completing while the reply FSM is not in R_IDLE: `last_addr` is still updated, the new reply is dropped, and `overrun` is set.
- Reset: all RAM bytes, `last_addr`, both FSMs, `overrun` and `bad_cmd` clear to 0. `rx_pins`=0 and `busy`=0 immediately on assertion. A reset mid-frame aborts the frame; the next start bit is honoured only after release.

## Timing
- Start at cycle t0: header sampled t0+1, payload t0+2..t0+9, execute at end of t0+9.
- Read reply: R_START at t0+10+REPLY_DELAY, data t0+11+REPLY_DELAY .. t0+18+REPLY_DELAY.
- A written byte is visible on `peek_data` from t0+10.
- `busy` rises in t0+1, the cycle after the start cycle is registered, and falls after the last reply data cycle, or after t0+9 for writes.
- In the cycle after a payload ends, a high `tx_pins[0]` is a start bit. During HEADER and PAYLOAD, `tx_pins` is never interpreted as a start.

## Structure
- Package `mem_link_pkg`: header codes TX_HEADER_READ_16=0, TX_HEADER_WRITE_8=1, TX_HEADER_WRITE_16=2; RX start pattern 2'b01; receiver and reply state enums.
- Sub-module `mem_reply_tx`: reply FSM, delay counter and 16-bit output shift register, loaded by a one-cycle `start` with a word, exposing `idle`.

## Test plan
- Reset, then WRITE via READ_16 A=0x04, WRITE_16 0xBEEF -> `peek` 0x04=0xEF, 0x05=0xBE; READ_16 0x04 reply payload 0xBEEF at t0+10+REPLY_DELAY.
- READ_16 A=0x1F (MEM_ADDR_BITS=5) after writing 0x1F=0x12, 0x00=0x34 -> reply 0x3412 (wrap).
- WRITE_8 0x00AA after READ_16 0x03 -> mem[3]=0xAA, mem[4] unchanged.
- Two READ_16 back-to-back with REPLY_DELAY=4 -> second dropped, `overrun`=1, first reply intact.
- Header 3 -> `bad_cmd`=1, RAM unchanged, no RX frame.
- `rst_n` low during R_DATA -> `rx_pins`=0 immediately; after release a READ_16 works normally.
